// File: rtl/sequential_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Results stay on quotient/remainder until the next accepted operation.
module sequential_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_ext;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;

  // Bit WIDTH of the (WIDTH+1)-bit difference is the borrow, since rem_ext < 2*divisor.
  always_comb begin
    rem_ext  = {rem_q, dvd_q[WIDTH-1]};
    trial    = rem_ext - {1'b0, divisor_q};
    borrow   = trial[WIDTH];
    rem_next = borrow ? rem_ext[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_next = {dvd_q[WIDTH-2:0], ~borrow};
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (B == '0) begin
            quotient_d  = '1;
            remainder_d = A;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
          end else begin
            dvd_d     = A;
            divisor_d = B;
            rem_d     = '0;
            count_d   = '0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        rem_d   = rem_next;
        dvd_d   = dvd_next;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          quotient_d  = dvd_next;
          remainder_d = rem_next;
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          count_d     = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed self-checking bench for sequential_divider (WIDTH=4, 10 ns clock).
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_sequential_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks;
  int errors;

  sequential_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start pulse, then follows the operation up to the done pulse (bounded).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int busy_cycles, output logic got_done, output logic overlap);
    A = a;
    B = b;
    start = 1'b1;
    step();
    start = 1'b0;
    busy_cycles = 0;
    got_done = 1'b0;
    overlap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done && busy) overlap = 1'b1;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    step();
    step();
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
  endtask

  task automatic test_basic();
    int   bc;
    logic gd;
    logic ov;
    do_op(4'd13, 4'd3, bc, gd, ov);
    checks++;
    if (bc !== 4 || gd !== 1'b1 || ov !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_timing: busy_cycles=%0d done=%b overlap=%b, want 4 1 0", bc, gd, ov);
    end
    checks++;
    if (quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_13_3: got q=%0d r=%0d dbz=%b, want q=4 r=1 dbz=0",
               quotient, remainder, div_by_zero);
    end
    A = 4'd7;
    B = 4'd2;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (quotient !== 4'd4 || remainder !== 4'd1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_hold: got q=%0d r=%0d done=%b busy=%b, want q=4 r=1 done=0 busy=0",
               quotient, remainder, done, busy);
    end
  endtask

  task automatic test_div_zero();
    int   bc;
    logic gd;
    logic ov;
    do_op(4'd9, 4'd0, bc, gd, ov);
    checks++;
    if (bc !== 0 || gd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dbz_timing: busy_cycles=%0d done=%b, want 0 1", bc, gd);
    end
    checks++;
    if (quotient !== 4'd15 || remainder !== 4'd9 || div_by_zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dbz_9_0: got q=%0d r=%0d dbz=%b, want q=15 r=9 dbz=1",
               quotient, remainder, div_by_zero);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dbz_single_pulse: got done=%b busy=%b dbz=%b, want 0 0 1",
               done, busy, div_by_zero);
    end
    do_op(4'd6, 4'd2, bc, gd, ov);
    checks++;
    if (gd !== 1'b1 || quotient !== 4'd3 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dbz_clear_6_2: got done=%b q=%0d r=%0d dbz=%b, want 1 q=3 r=0 dbz=0",
               gd, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W-1:0] vq [4];
    logic [W-1:0] vr [4];
    int   bc;
    logic gd;
    logic ov;
    va = '{4'd15, 4'd7, 4'd0, 4'd15};
    vb = '{4'd1,  4'd9, 4'd5, 4'd15};
    vq = '{4'd15, 4'd0, 4'd0, 4'd1};
    vr = '{4'd0,  4'd7, 4'd0, 4'd0};
    for (int i = 0; i < 4; i++) begin
      step();
      do_op(va[i], vb[i], bc, gd, ov);
      checks++;
      if (gd !== 1'b1 || bc !== 4 || quotient !== vq[i] || remainder !== vr[i]) begin
        errors++;
        $display("[TB] FAIL boundary_%0d_%0d: got done=%b busy_cycles=%0d q=%0d r=%0d, want 1 4 q=%0d r=%0d",
                 va[i], vb[i], gd, bc, quotient, remainder, vq[i], vr[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   bc;
    logic gd;
    logic ov;
    A = 4'd13;
    B = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    A = 4'd15;
    B = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    step();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_busy_state: got busy=%b done=%b, want 1 0", busy, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd1) begin
      errors++;
      $display("[TB] FAIL ignore_start_result: got done=%b q=%0d r=%0d, want 1 q=4 r=1",
               done, quotient, remainder);
    end
    do_op(4'd15, 4'd1, bc, gd, ov);
    checks++;
    if (gd !== 1'b1 || bc !== 4 || ov !== 1'b0 || quotient !== 4'd15 || remainder !== 4'd0) begin
      errors++;
      $display("[TB] FAIL back_to_back_15_1: got done=%b busy_cycles=%0d overlap=%b q=%0d r=%0d, want 1 4 0 q=15 r=0",
               gd, bc, ov, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_run();
    int   bc;
    logic gd;
    logic ov;
    logic saw_done;
    step();
    A = 4'd10;
    B = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    step();
    rst = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) saw_done = 1'b1;
      step();
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: got done_or_busy=%b, want 0", saw_done);
    end
    do_op(4'd10, 4'd3, bc, gd, ov);
    checks++;
    if (gd !== 1'b1 || quotient !== 4'd3 || remainder !== 4'd1) begin
      errors++;
      $display("[TB] FAIL after_reset_10_3: got done=%b q=%0d r=%0d, want 1 q=3 r=1",
               gd, quotient, remainder);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    #1;
    test_reset();
    test_basic();
    test_div_zero();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
